selftrigger_record_capture: RTL
===============================

SELFTRIGGER_RECORD_CAPTURE -- requirements
Module: selftrigger_record_capture

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning sample buffer depth = 2^ADDR_W words.
REQ-002 The block SHALL have parameter PRE_SAMPLES, default 64, meaning pre-trigger samples per record.
REQ-003 The block SHALL have parameter REC_SAMPLES, default 512, meaning total samples per record; legal only if PRE_SAMPLES < REC_SAMPLES <= 2^ADDR_W.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  sample strobe; x and trigger are taken only when enable=1.
REQ-007 x  input  16  signed filtered sample stream from the self-trigger filter.
REQ-008 trigger  input  1  self-trigger level from the filter; only its rising edge, sampled with enable=1, is an event.
REQ-009 dout  output  16  record sample word.
REQ-010 dout_valid  output  1  dout holds a valid word.
REQ-011 dout_ready  input  1  downstream accepts the word; a transfer occurs when dout_valid=1 and dout_ready=1.
REQ-012 dout_last  output  1  high with the final (REC_SAMPLES-th) word of a record.
REQ-013 timestamp  output  32  enable-count value at the trigger edge; stable from the first word to the last word of the record.
REQ-014 armed  output  1  high only in state ARMED.
REQ-015 missed_count  output  16  number of trigger edges ignored while not armed.

Function
REQ-016 The block SHALL keep a 32-bit free-running counter ts_cnt, incremented on every enable=1 cycle and wrapping at 2^32.
REQ-017 The block SHALL implement the FSM FILL -> ARMED -> POST -> READ -> FILL.
REQ-018 FILL: each enable=1 cycle writes x to the circular buffer at wr_ptr and increments wr_ptr modulo 2^ADDR_W; after PRE_SAMPLES writes the FSM goes to ARMED.
REQ-019 ARMED: the block keeps writing; a trigger edge on enable=1 cycle k records start = wr_ptr - PRE_SAMPLES (mod 2^ADDR_W), latches timestamp = ts_cnt, writes sample k, and goes to POST.
REQ-020 POST: the block writes until REC_SAMPLES - PRE_SAMPLES samples, including sample k, are written since the edge, then goes to READ.
REQ-021 READ: buffer writes are suspended; the block streams REC_SAMPLES words oldest-first, starting at address start and wrapping modulo 2^ADDR_W; after the transfer with dout_last=1 the FSM goes to FILL.
REQ-022 The record SHALL be samples k-PRE_SAMPLES through k+REC_SAMPLES-PRE_SAMPLES-1, exactly, with no gaps or duplicates.
REQ-023 Buffer read latency SHALL be 1 cycle; dout_valid SHALL assert within 3 clk cycles of entering READ.
REQ-024 While dout_valid=1 and dout_ready=0, dout, dout_last and dout_valid SHALL hold stable.
REQ-025 With dout_ready held at 1, words SHALL transfer on consecutive cycles with no bubbles.
REQ-026 A trigger edge in FILL, POST or READ SHALL increment missed_count, saturating at 0xFFFF, and SHALL otherwise be ignored.
REQ-027 Rising-edge detection SHALL use the previous trigger value sampled at enable=1; a trigger held high across FILL -> ARMED SHALL NOT fire.
REQ-028 With enable=0, no writes, edge detection or ts_cnt updates occur; READ output handshaking continues.

Reset
REQ-029 On reset=0: FSM=FILL, wr_ptr=0, ts_cnt=0, missed_count=0, dout=0, dout_valid=0, dout_last=0, timestamp=0, armed=0, trigger history=0.
REQ-030 Reset asserted mid-READ SHALL abort the record immediately: dout_valid=0 and no further words are emitted; after release, capture restarts with FILL.

Verification (ADDR_W=4, PRE_SAMPLES=4, REC_SAMPLES=8, enable=1, x = ramp 0,1,2,...)
REQ-031 Scenario 1: trigger rises with x=20, ready=1 -> 8 words 16..23 on consecutive cycles, dout_last on 23, timestamp=20.
REQ-032 Scenario 2: as scenario 1, but ready toggles 1,0,0,1,... -> same 8 words in order, each held stable while ready=0.
REQ-033 Scenario 3: trigger rises at x=14 with wr_ptr near 15 -> record 10..17, correct across the address wrap.
REQ-034 Scenario 4: second trigger edge during POST, two more during READ -> missed_count=3, a single record is emitted.
REQ-035 Scenario 5: reset pulsed after the 3rd word of a record -> dout_valid=0 within 1 cycle, all outputs at reset values; the next trigger at x=30 (ramp restarted at 0) yields 26..33 with timestamp=30.
REQ-036 Scenario 6: trigger held high from reset through FILL -> no record until trigger falls and rises again in ARMED.

Source files
------------

// File: rtl/selftrigger_record_capture.sv
// Self-triggered record capture: a circular sample buffer keeps a pre-trigger
// history, a rising trigger edge freezes a window around it, and the window is
// streamed out oldest-first over a valid/ready interface.
module selftrigger_record_capture #(
  parameter int ADDR_W      = 10,
  parameter int PRE_SAMPLES = 64,
  parameter int REC_SAMPLES = 512,
  parameter int DATA_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] x,
  input  logic                     trigger,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic [31:0]              timestamp,
  output logic                     armed,
  output logic [15:0]              missed_count
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int POST_N = REC_SAMPLES - PRE_SAMPLES;

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'((PRE_SAMPLES > 0) ? PRE_SAMPLES - 1 : 0);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_N - 1);
  localparam logic [CNT_W-1:0]  REC_LAST  = CNT_W'(REC_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  REC_CNT   = CNT_W'(REC_SAMPLES);
  localparam logic [ADDR_W-1:0] PRE_ADDR  = ADDR_W'(PRE_SAMPLES);

  typedef enum logic [1:0] {FILL, ARMED, POST, READ} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         rd_cnt;
  logic [31:0]              ts_cnt;
  logic                     trig_prev;

  logic trig_rise;
  logic wr_en;
  logic issue;
  logic done;

  // Saturating event counter increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A trigger event is a 0->1 change between two enabled samples; writes stop
  // while a record is being read so the frozen window cannot be overwritten.
  // A new word is fetched whenever the output register is empty or draining.
  always_comb begin
    trig_rise = enable & trigger & ~trig_prev;
    wr_en     = enable & (state != READ);
    issue     = (state == READ) && (!dout_valid || dout_ready) && (rd_cnt < REC_CNT);
    done      = dout_valid & dout_ready & dout_last;
    armed     = (state == ARMED);
  end

  // Next-state logic for the capture sequence.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (PRE_SAMPLES == 0)
          state_next = ARMED;
        else if (enable && cnt == PRE_LAST)
          state_next = ARMED;
      end
      ARMED: begin
        if (trig_rise)
          state_next = (POST_N == 1) ? READ : POST;
      end
      POST: begin
        if (enable && cnt == POST_LAST)
          state_next = READ;
      end
      READ: begin
        if (done)
          state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Sample buffer write port; memory contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= x;
  end

  // Control state, counters, trigger bookkeeping and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      rd_cnt       <= '0;
      ts_cnt       <= '0;
      trig_prev    <= 1'b0;
      missed_count <= '0;
      timestamp    <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      dout_last    <= 1'b0;
    end else begin
      state <= state_next;

      if (enable) begin
        ts_cnt    <= ts_cnt + 32'd1;
        trig_prev <= trigger;
      end

      if (wr_en)
        wr_ptr <= wr_ptr + ADDR_W'(1);

      if (trig_rise && state != ARMED)
        missed_count <= sat_inc16(missed_count);

      // cnt counts samples written in FILL, and samples since the edge in POST
      if (state_next != state)
        cnt <= (state_next == POST) ? CNT_W'(1) : '0;
      else if (enable && (state == FILL || state == POST))
        cnt <= cnt + CNT_W'(1);

      if (state == ARMED && trig_rise) begin
        rd_ptr    <= wr_ptr - PRE_ADDR;
        timestamp <= ts_cnt;
      end

      if (state != READ)
        rd_cnt <= '0;

      // read stage: address rd_ptr -> dout register, held while stalled
      if (issue) begin
        dout       <= mem[rd_ptr];
        dout_valid <= 1'b1;
        dout_last  <= (rd_cnt == REC_LAST);
        rd_ptr     <= rd_ptr + ADDR_W'(1);
        rd_cnt     <= rd_cnt + CNT_W'(1);
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule
